// File: rtl/fir_interp.sv
// rtl/fir_interp.sv - polyphase interpolating FIR between FIFOs; optional clipping via FIR_INTERP_SATURATE_EN
package radio_const_pkg;
  localparam logic signed [15:0] TEST_COEFFS [32] = '{
    16'sd0,   -16'sd4,  -16'sd8,  -16'sd6,  16'sd6,   16'sd20,  16'sd24,  16'sd4,
    -16'sd34, -16'sd60, -16'sd40, 16'sd34,  16'sd140, 16'sd232, 16'sd296, 16'sd320,
    16'sd320, 16'sd296, 16'sd232, 16'sd140, 16'sd34,  -16'sd40, -16'sd60, -16'sd34,
    16'sd4,   16'sd24,  16'sd20,  16'sd6,   -16'sd6,  -16'sd8,  -16'sd4,  16'sd0
  };
endpackage

module fir_interp #(
  parameter int INTERP          = 2,
  parameter int FIFO_DATA_WIDTH = 16,
  parameter int NUM_TAPS        = 32,
  parameter int COEFF_WIDTH     = 16,
  parameter int QUANT_BITS      = 10,
  parameter logic signed [COEFF_WIDTH-1:0] COEFFS [NUM_TAPS] = radio_const_pkg::TEST_COEFFS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FIFO_DATA_WIDTH-1:0] in_dout,
  input  logic                       in_empty,
  output logic                       in_rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] out_din,
  input  logic                       out_full,
  output logic                       out_wr_en
);
  localparam int W   = FIFO_DATA_WIDTH;
  localparam int CW  = COEFF_WIDTH;
  localparam int TPP = NUM_TAPS / INTERP;
  localparam int AW  = W + CW + ((TPP > 1) ? $clog2(TPP) : 1);
  localparam int KW  = (TPP > 1) ? $clog2(TPP) : 1;
  localparam int PW  = $clog2(INTERP);
  localparam int IW  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [KW-1:0] K_LAST = KW'(TPP - 1);
  localparam logic [PW-1:0] P_LAST = PW'(INTERP - 1);

  logic [1:0]              state;
  logic [KW-1:0]           k;
  logic [PW-1:0]           phase;
  logic signed [AW-1:0]    acc;
  logic signed [W-1:0]     x [TPP];
  logic                    rst_q;
  logic                    pop;
  logic                    wr_fire;
  logic [IW-1:0]           cidx;
  logic signed [CW-1:0]    coef_sel;
  logic signed [W-1:0]     x_sel;
  logic signed [W+CW-1:0]  prod;
  logic [W-1:0]            result;

  // Pops are held off during reset and the cycle after it; writes only when downstream has room.
  assign pop       = (state == S_IDLE) && !in_empty && !rst && !rst_q;
  assign wr_fire   = (state == S_WRITE) && !out_full && !rst;
  assign in_rd_en  = pop;
  assign out_wr_en = wr_fire;
  assign out_din   = ((state == S_WRITE) && !rst) ? result : '0;

  // Tap selection for the current polyphase branch and the single shared product.
  always_comb begin
    cidx     = IW'(int'(k) * INTERP + int'(phase));
    coef_sel = COEFFS[cidx];
    x_sel    = x[k];
    prod     = x_sel * coef_sel;
  end

`ifdef FIR_INTERP_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  logic signed [AW-1:0] shifted;

  // Floor-shift the accumulator, then clip into the output sample range.
  always_comb begin
    shifted = acc >>> QUANT_BITS;
    if (shifted > SAT_MAX)      result = SAT_MAX[W-1:0];
    else if (shifted < SAT_MIN) result = SAT_MIN[W-1:0];
    else                        result = shifted[W-1:0];
  end
`else
  // Floor-shift the accumulator and keep the low W bits (two's-complement wrap).
  always_comb begin
    result = acc[QUANT_BITS +: W];
  end
`endif

  // Control FSM, delay line and accumulator; reset abandons any sample in flight and clears history.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      phase <= '0;
      acc   <= '0;
      for (int i = 0; i < TPP; i++) x[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            x[0] <= $signed(in_dout);
            for (int i = 1; i < TPP; i++) x[i] <= x[i-1];
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc   <= '0;
          k     <= '0;
          phase <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          acc <= acc + AW'(prod);
          k   <= k + KW'(1);
          if (k == K_LAST) state <= S_WRITE;
        end
        default: begin
          if (wr_fire) begin
            if (phase != P_LAST) begin
              phase <= phase + PW'(1);
              acc   <= '0;
              k     <= '0;
              state <= S_MAC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end
endmodule
